// File: rtl/rs_encode_stream_out_engine.sv
// ---------------------------------------------------------------------------
// rs_encode_stream_out_engine
//
// Output stage of the RS encoder. Encoded data lines pass straight through to
// the output stream, while the parity of every RS block is packed PACK blocks
// per line into an internal buffer. Depending on the per-request mode the
// packed parity is emitted either after every group of PACK blocks (INLINE)
// or after all data of the request (APPEND). The final parity beat of a
// request carries out_last.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_val/req_rdy   request metadata handshake (req_num_blocks, req_mode:
//                     0 = APPEND, 1 = INLINE); accepted only while idle
//   enc_val/enc_rdy   encoded line input (enc_line, enc_parity; the parity
//                     is sampled on the last line of each block only)
//   out_val/out_rdy   output stream (out_data, out_last)
//   busy              a request is in progress
//   stall_cnt         (only with RS_ENC_OUT_STALL_CNT_EN) saturating count of
//                     cycles with out_val=1 and out_rdy=0, cleared on request
//                     accept
//
// Optional feature macro: RS_ENC_OUT_STALL_CNT_EN
// ---------------------------------------------------------------------------
module rs_encode_stream_out_engine #(
    parameter int DATA_W           = 256,
    parameter int RS_DATA_BYTES    = 128,
    parameter int RS_T             = 8,
    parameter int NUM_REQ_BLOCKS   = 64,
    parameter int NUM_REQ_BLOCKS_W = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_val,
    input  logic [NUM_REQ_BLOCKS_W-1:0] req_num_blocks,
    input  logic                        req_mode,
    output logic                        req_rdy,
    input  logic                        enc_val,
    input  logic [DATA_W-1:0]           enc_line,
    input  logic [8*RS_T-1:0]           enc_parity,
    output logic                        enc_rdy,
    output logic                        out_val,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_rdy,
    output logic                        busy
`ifdef RS_ENC_OUT_STALL_CNT_EN
   ,output logic [31:0]                 stall_cnt
`endif
);

    localparam int DATA_BYTES     = DATA_W / 8;
    localparam int NUM_DATA_LINES = RS_DATA_BYTES / DATA_BYTES;
    localparam int PARITY_W       = 8 * RS_T;
    localparam int PACK           = DATA_BYTES / RS_T;
    localparam int BUF_LINES      = (NUM_REQ_BLOCKS + PACK - 1) / PACK;
    localparam int CNT_W          = NUM_REQ_BLOCKS_W + 1;
    localparam int LINE_W         = (NUM_DATA_LINES > 1) ? $clog2(NUM_DATA_LINES) : 1;
    localparam int BUF_AW         = (BUF_LINES > 1) ? $clog2(BUF_LINES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        PAR_IN  = 2'd2,
        PAR_APP = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    num_blocks;
    logic [CNT_W-1:0]    blk_cnt;
    logic                mode;
    logic [LINE_W-1:0]   line_cnt;
    logic [BUF_AW-1:0]   rd_ptr;
    logic [DATA_W-1:0]   par_buf [BUF_LINES];

    logic                req_take;
    logic                line_last;
    logic                enc_xfer;
    logic                blk_done;
    logic                last_blk;
    logic                slot_last;
    logic [CNT_W-1:0]    slot_idx;
    logic [31:0]         slot_base;
    logic [BUF_AW-1:0]   wr_idx;
    logic [CNT_W-1:0]    par_lines;
    logic                rd_last;

    // Handshake and position decodes shared by the FSM and the datapath.
    // INLINE parity never needs more than one line, so it always targets line 0.
    always_comb begin
        req_take  = (state == IDLE) && req_val;
        line_last = (line_cnt == LINE_W'(NUM_DATA_LINES - 1));
        enc_xfer  = (state == DATA) && enc_val && out_rdy;
        blk_done  = enc_xfer && line_last;
        last_blk  = ((blk_cnt + CNT_W'(1)) == num_blocks);
        slot_idx  = blk_cnt % CNT_W'(PACK);
        slot_last = (slot_idx == CNT_W'(PACK - 1));
        slot_base = 32'(slot_idx) * PARITY_W;
        wr_idx    = mode ? '0 : BUF_AW'(blk_cnt / CNT_W'(PACK));
        par_lines = (num_blocks + CNT_W'(PACK - 1)) / CNT_W'(PACK);
        rd_last   = (CNT_W'(rd_ptr) == (par_lines - CNT_W'(1)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and stream outputs. DATA is a zero-latency passthrough; the
    // parity states present a buffer line and hold it until it is taken.
    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        enc_rdy   = 1'b0;
        out_val   = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val && (req_num_blocks != '0)) state_nxt = DATA;
            end
            DATA: begin
                out_val  = enc_val;
                out_data = enc_line;
                enc_rdy  = out_rdy;
                if (blk_done) begin
                    if (mode && (slot_last || last_blk)) state_nxt = PAR_IN;
                    else if (!mode && last_blk)          state_nxt = PAR_APP;
                end
            end
            PAR_IN: begin
                // blk_cnt was already advanced past the block that filled this line
                out_val  = 1'b1;
                out_data = par_buf[0];
                out_last = (blk_cnt == num_blocks);
                if (out_rdy) state_nxt = (blk_cnt == num_blocks) ? IDLE : DATA;
            end
            PAR_APP: begin
                out_val  = 1'b1;
                out_data = par_buf[rd_ptr];
                out_last = rd_last;
                if (out_rdy && rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Request metadata and position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_blocks <= '0;
            mode       <= 1'b0;
            blk_cnt    <= '0;
            line_cnt   <= '0;
            rd_ptr     <= '0;
        end else if (req_take) begin
            num_blocks <= CNT_W'(req_num_blocks);
            mode       <= req_mode;
            blk_cnt    <= '0;
            line_cnt   <= '0;
            rd_ptr     <= '0;
        end else begin
            if (enc_xfer) line_cnt <= line_last ? '0 : line_cnt + LINE_W'(1);
            if (blk_done) blk_cnt  <= blk_cnt + CNT_W'(1);
            if ((state == PAR_APP) && out_rdy) rd_ptr <= rd_ptr + BUF_AW'(1);
        end
    end

    // Parity buffer: cleared at the start of every request so unfilled slots
    // read as zero; an INLINE line is cleared again once it has been sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_LINES; i++) par_buf[i] <= '0;
        end else if (req_take) begin
            for (int i = 0; i < BUF_LINES; i++) par_buf[i] <= '0;
        end else if (blk_done) begin
            par_buf[wr_idx][slot_base +: PARITY_W] <= enc_parity;
        end else if ((state == PAR_IN) && out_rdy) begin
            par_buf[0] <= '0;
        end
    end

`ifdef RS_ENC_OUT_STALL_CNT_EN
    // Backpressure statistics, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          stall_cnt <= '0;
        else if (req_take)                                   stall_cnt <= '0;
        else if (out_val && !out_rdy && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rs_encode_stream_out_engine.sv
// ---------------------------------------------------------------------------
// tb_rs_encode_stream_out_engine
//
// Self-checking bench for rs_encode_stream_out_engine with the default
// geometry (4 lines per block, PACK = 4). Each request builds its expected
// beat list from the block data and parity, and a monitor compares every
// accepted output beat against that list and checks that a stalled beat is
// held stable. Directed runs additionally pin a few packed parity lines to
// literal values. Build with RS_ENC_OUT_STALL_CNT_EN to also exercise
// stall_cnt.
// ---------------------------------------------------------------------------
module tb_rs_encode_stream_out_engine;

    localparam int DATA_W = 256;
    localparam int PW     = 64;
    localparam int LINES  = 4;
    localparam int PACK   = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_val;
    logic [6:0]        req_num_blocks;
    logic              req_mode;
    logic              req_rdy;
    logic              enc_val;
    logic [DATA_W-1:0] enc_line;
    logic [PW-1:0]     enc_parity;
    logic              enc_rdy;
    logic              out_val;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_rdy;
    logic              busy;
`ifdef RS_ENC_OUT_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    beat_t             exp_q[$];
    beat_t             cap_q[$];
    logic [DATA_W-1:0] line_q[$];
    logic [PW-1:0]     par_q[$];
    int                beat_cnt = 0;
    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;

    localparam logic [DATA_W-1:0] LIT_FULL = {64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0002,
                                              64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [DATA_W-1:0] LIT_ONE4 = {192'h0, 64'hA0A0_0000_0000_0004};
    localparam logic [DATA_W-1:0] LIT_ONE0 = {192'h0, 64'hA0A0_0000_0000_0000};

    always #5 clk = ~clk;

    rs_encode_stream_out_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_val        (req_val),
        .req_num_blocks (req_num_blocks),
        .req_mode       (req_mode),
        .req_rdy        (req_rdy),
        .enc_val        (enc_val),
        .enc_line       (enc_line),
        .enc_parity     (enc_parity),
        .enc_rdy        (enc_rdy),
        .out_val        (out_val),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_rdy        (out_rdy),
        .busy           (busy)
`ifdef RS_ENC_OUT_STALL_CNT_EN
       ,.stall_cnt      (stall_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_req_rdy",  256'(req_rdy),  256'(1));
        checkOutput("rst_enc_rdy",  256'(enc_rdy),  256'(0));
        checkOutput("rst_out_val",  256'(out_val),  256'(0));
        checkOutput("rst_out_last", 256'(out_last), 256'(0));
        checkOutput("rst_out_data", out_data,       256'(0));
        checkOutput("rst_busy",     256'(busy),     256'(0));
    endtask

    // Monitor: every accepted beat must be the next expected one, and a beat
    // that was offered but not taken must reappear unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checkOutput("hold_val",  256'(out_val), 256'(1));
                checkOutput("hold_data", out_data,      hold_data);
            end
            if (out_val && out_rdy) begin
                beat_t e;
                beat_cnt++;
                cap_q.push_back('{data: out_data, last: out_last});
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_beat: got beat %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_data", out_data,       e.data);
                    checkOutput("beat_last", 256'(out_last), 256'(e.last));
                end
            end
            hold_prev = out_val && !out_rdy;
            hold_data = out_data;
        end
    end

    // Runs one request: generates blocks, derives the expected beat list,
    // issues the metadata and drives lines with random gaps/backpressure.
    // abort_after >= 0 returns right after that output beat index is taken.
    task automatic applyStimulus(input int n, input bit mode, input int rdy_pct,
                                 input int val_pct, input bit directed,
                                 input int abort_after, input int stall_cycles);
        logic [DATA_W-1:0] dl[$];
        logic [PW-1:0]     bp[$];
        logic [DATA_W-1:0] line;
        logic [DATA_W-1:0] word;
        int                cyc;
        bit                take;
        for (int b = 0; b < n; b++) begin
            bp.push_back(directed ? (64'hA0A0_0000_0000_0000 | 64'(b)) : {$urandom, $urandom});
            for (int l = 0; l < LINES; l++) begin
                if (directed) line = {8{32'(b * 16 + l)}};
                else for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
                dl.push_back(line);
                line_q.push_back(line);
                par_q.push_back((l == LINES - 1) ? bp[b] : {$urandom, $urandom});
            end
        end
        // Expected output stream
        if (!mode) begin
            for (int i = 0; i < n * LINES; i++) exp_q.push_back('{data: dl[i], last: 1'b0});
            for (int k = 0; k < (n + PACK - 1) / PACK; k++) begin
                word = '0;
                for (int j = 0; j < PACK; j++)
                    if (k * PACK + j < n) word[j*PW +: PW] = bp[k * PACK + j];
                exp_q.push_back('{data: word, last: (k == (n + PACK - 1) / PACK - 1)});
            end
        end else begin
            for (int g = 0; g < n; g += PACK) begin
                word = '0;
                for (int j = 0; j < PACK && g + j < n; j++) begin
                    for (int l = 0; l < LINES; l++)
                        exp_q.push_back('{data: dl[(g + j) * LINES + l], last: 1'b0});
                    word[j*PW +: PW] = bp[g + j];
                end
                exp_q.push_back('{data: word, last: (g + PACK >= n)});
            end
        end
        cap_q.delete();
        beat_cnt = 0;
        @(posedge clk); #1;
        req_val        = 1'b1;
        req_num_blocks = 7'(n);
        req_mode       = mode;
        @(negedge clk);
        checkOutput("req_rdy_idle", 256'(req_rdy), 256'(1));
        @(posedge clk); #1;
        req_val = 1'b0;
`ifdef RS_ENC_OUT_STALL_CNT_EN
        checkOutput("stall_clear", 256'(stall_cnt), 256'(0));
`endif
        cyc = 0;
        forever begin
            if (abort_after >= 0 && beat_cnt > abort_after) return;
            if (line_q.size() == 0 && !enc_val && exp_q.size() == 0) break;
            if (cyc >= 8000) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout: got %0d beats left expected 0", exp_q.size());
                exp_q.delete();
                line_q.delete();
                par_q.delete();
                enc_val = 1'b0;
                return;
            end
            out_rdy = (cyc < stall_cycles) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (!enc_val && line_q.size() > 0 &&
                (cyc < stall_cycles || $urandom_range(99) < val_pct)) begin
                enc_val    = 1'b1;
                enc_line   = line_q[0];
                enc_parity = par_q[0];
            end
            @(negedge clk);
            take = enc_val && enc_rdy;
            @(posedge clk); #1;
            if (take) begin
                void'(line_q.pop_front());
                void'(par_q.pop_front());
                enc_val = 1'b0;
            end
            cyc++;
        end
        checkOutput("busy_end",    256'(busy),    256'(0));
        checkOutput("req_rdy_end", 256'(req_rdy), 256'(1));
        checkOutput("enc_rdy_end", 256'(enc_rdy), 256'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        req_val        = 1'b0;
        req_num_blocks = '0;
        req_mode       = 1'b0;
        enc_val        = 1'b0;
        enc_line       = '0;
        enc_parity     = '0;
        out_rdy        = 1'b0;
        #12;
        checkReset();
        rst_n = 1'b1;

        // APPEND, 5 blocks, no backpressure
        applyStimulus(5, 1'b0, 100, 100, 1'b1, -1, 0);
        checkOutput("app5_count",  256'(cap_q.size()), 256'(22));
        if (cap_q.size() == 22) begin
            checkOutput("app5_data5",  cap_q[5].data,        {8{32'd17}});
            checkOutput("app5_last19", 256'(cap_q[19].last), 256'(0));
            checkOutput("app5_par0",   cap_q[20].data,       LIT_FULL);
            checkOutput("app5_par1",   cap_q[21].data,       LIT_ONE4);
            checkOutput("app5_last21", 256'(cap_q[21].last), 256'(1));
        end

        // INLINE, 5 blocks
        applyStimulus(5, 1'b1, 100, 100, 1'b1, -1, 0);
        checkOutput("inl5_count", 256'(cap_q.size()), 256'(22));
        if (cap_q.size() == 22) begin
            checkOutput("inl5_par16",  cap_q[16].data,       LIT_FULL);
            checkOutput("inl5_last16", 256'(cap_q[16].last), 256'(0));
            checkOutput("inl5_data17", cap_q[17].data,       {8{32'd64}});
            checkOutput("inl5_par21",  cap_q[21].data,       LIT_ONE4);
            checkOutput("inl5_last21", 256'(cap_q[21].last), 256'(1));
        end

        // Zero-block request is ignored
        @(posedge clk); #1;
        req_val        = 1'b1;
        req_num_blocks = '0;
        req_mode       = 1'b0;
        out_rdy        = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("zero_out_val", 256'(out_val), 256'(0));
            checkOutput("zero_busy",    256'(busy),    256'(0));
            checkOutput("zero_req_rdy", 256'(req_rdy), 256'(1));
        end

        // Maximum-size APPEND under random backpressure
        applyStimulus(64, 1'b0, 60, 70, 1'b0, -1, 0);
        checkOutput("app64_count", 256'(cap_q.size()), 256'(64 * LINES + 16));

        // Assorted random requests
        for (int r = 0; r < 6; r++)
            applyStimulus($urandom_range(20, 1), 1'($urandom_range(1)),
                          $urandom_range(90, 40), $urandom_range(90, 40), 1'b0, -1, 0);

        // Reset after beat 7 of a 2-block request
        applyStimulus(2, 1'b0, 100, 100, 1'b0, 7, 0);
        rst_n = 1'b0;
        #1;
        checkReset();
        exp_q.delete();
        line_q.delete();
        par_q.delete();
        enc_val = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        applyStimulus(1, 1'b1, 100, 100, 1'b1, -1, 0);
        checkOutput("post_rst_count", 256'(cap_q.size()), 256'(5));
        if (cap_q.size() == 5) begin
            checkOutput("post_rst_par",  cap_q[4].data,       LIT_ONE0);
            checkOutput("post_rst_last", 256'(cap_q[4].last), 256'(1));
        end

`ifdef RS_ENC_OUT_STALL_CNT_EN
        applyStimulus(1, 1'b0, 100, 100, 1'b0, -1, 10);
        checkOutput("stall_cnt10", 256'(stall_cnt), 256'(10));
        applyStimulus(1, 1'b0, 100, 100, 1'b0, -1, 0);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
